// File: rtl/axi_req_arbiter_pkg.sv
// Shared definitions for the IF/MEM AXI request arbiter.
//   arb_state_t  : arbiter FSM states (idle / waiting for master completion)
//   req_id_t     : requester identities used for the owner register
//   streak_width : width of the MEM-grant streak counter for a given limit
package axi_req_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

    // A limit of 0 still needs a 1-bit counter so the register stays legal.
    function automatic int unsigned streak_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/axi_req_arbiter_slot.sv
// One-deep request holding register for a single requester.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   start              one-cycle request pulse
//   we/addr/wdata/wstrb request fields sampled with start
//   clear              slot has been granted this cycle, empty it
//   owner_active       this requester's transaction is outstanding at the master
//   full               slot holds a request
//   req_we..req_wstrb  held request fields
//   overflow           start arrived while this requester was still busy (request dropped)
module arb_req_slot #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                clear,
    input  logic                owner_active,
    output logic                full,
    output logic                req_we,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W/8-1:0] req_wstrb,
    output logic                overflow
);

    assign overflow = start & (full | owner_active);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            full      <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
        end else if (start && !overflow) begin
            full      <= 1'b1;
            req_we    <= we;
            req_addr  <= addr;
            req_wdata <= wdata;
            req_wstrb <= wstrb;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_req_arbiter.sv
// Arbitrates the single AXI user-side port between instruction fetch (read-only)
// and the MEM stage. Start pulses are captured in one-deep slots; one transaction
// is granted at a time, MEM first, with an IF anti-starvation limit.
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   if_start/if_addr                  IF read request
//   if_busy/if_done/if_rdata          IF status, completion pulse, read data
//   mem_start/we/addr/wdata/wstrb     MEM request
//   mem_busy/mem_done/mem_rdata       MEM status, completion pulse, read data
//   m_start/we/addr/wdata/wstrb       registered request to the AXI master
//   m_busy/m_done/m_rdata             AXI master status, completion, read data
//   proto_err                         sticky: start while own request outstanding
module axi_req_arbiter
    import axi_req_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_start,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_busy,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_start,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_busy,
    output logic                mem_done,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                m_start,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_busy,
    input  logic                m_done,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                proto_err
);

    localparam int unsigned    SW         = streak_width(STARVE_MAX);
    localparam logic [SW-1:0]  STREAK_LIM = SW'(STARVE_MAX);

    arb_state_t     state, state_nxt;
    req_id_t        owner;
    logic [SW-1:0]  streak;

    logic                if_full, mem_full;
    logic                if_slot_we, mem_slot_we;
    logic [ADDR_W-1:0]   if_slot_addr, mem_slot_addr;
    logic [DATA_W-1:0]   if_slot_wdata, mem_slot_wdata;
    logic [DATA_W/8-1:0] if_slot_wstrb, mem_slot_wstrb;
    logic                if_ovf, mem_ovf;
    logic                if_active, mem_active;
    logic                grant_if, grant_mem;
    logic                if_starving;

    // A requester may restart in the cycle its done is seen, so the
    // outstanding-transaction guard drops out while m_done is high.
    assign if_active  = (state == ST_WAIT) && (owner == REQ_IF)  && !m_done;
    assign mem_active = (state == ST_WAIT) && (owner == REQ_MEM) && !m_done;

    arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_slot (
        .clk          (clk),
        .resetn       (resetn),
        .start        (if_start),
        .we           (1'b0),
        .addr         (if_addr),
        .wdata        ('0),
        .wstrb        ('0),
        .clear        (grant_if),
        .owner_active (if_active),
        .full         (if_full),
        .req_we       (if_slot_we),
        .req_addr     (if_slot_addr),
        .req_wdata    (if_slot_wdata),
        .req_wstrb    (if_slot_wstrb),
        .overflow     (if_ovf)
    );

    arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_slot (
        .clk          (clk),
        .resetn       (resetn),
        .start        (mem_start),
        .we           (mem_we),
        .addr         (mem_addr),
        .wdata        (mem_wdata),
        .wstrb        (mem_wstrb),
        .clear        (grant_mem),
        .owner_active (mem_active),
        .full         (mem_full),
        .req_we       (mem_slot_we),
        .req_addr     (mem_slot_addr),
        .req_wdata    (mem_slot_wdata),
        .req_wstrb    (mem_slot_wstrb),
        .overflow     (mem_ovf)
    );

    assign if_starving = (STARVE_MAX != 0) && (streak == STREAK_LIM);

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((if_full || mem_full) && !m_busy) begin
                    if (if_full && (!mem_full || if_starving)) begin
                        grant_if = 1'b1;
                    end else begin
                        grant_mem = 1'b1;
                    end
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            owner     <= REQ_IF;
            streak    <= '0;
            m_start   <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            proto_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            m_start <= grant_if | grant_mem;
            if (grant_if) begin
                owner   <= REQ_IF;
                m_we    <= if_slot_we;
                m_addr  <= if_slot_addr;
                m_wdata <= if_slot_wdata;
                m_wstrb <= if_slot_wstrb;
            end else if (grant_mem) begin
                owner   <= REQ_MEM;
                m_we    <= mem_slot_we;
                m_addr  <= mem_slot_addr;
                m_wdata <= mem_slot_wdata;
                m_wstrb <= mem_slot_wstrb;
            end
            // Streak counts MEM grants that bypassed a waiting IF request.
            if (grant_if || !if_full) begin
                streak <= '0;
            end else if (grant_mem && (streak != STREAK_LIM)) begin
                streak <= streak + 1'b1;
            end
            if (if_ovf || mem_ovf) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign if_busy   = if_full  | ((state == ST_WAIT) && (owner == REQ_IF));
    assign mem_busy  = mem_full | ((state == ST_WAIT) && (owner == REQ_MEM));
    assign if_done   = (state == ST_WAIT) && m_done && (owner == REQ_IF);
    assign mem_done  = (state == ST_WAIT) && m_done && (owner == REQ_MEM);
    assign if_rdata  = m_rdata;
    assign mem_rdata = m_rdata;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Scoreboard bench for axi_req_arbiter: requests are queued when issued, and a
// negedge monitor predicts grant timing, grant choice, busy and done routing.
module tb_axi_req_arbiter;

    localparam int SMAX    = 2;
    localparam int NONE    = 0;
    localparam int OWN_IF  = 1;
    localparam int OWN_MEM = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_start;
    logic [31:0] if_addr;
    logic        if_busy, if_done;
    logic [31:0] if_rdata;
    logic        mem_start, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_busy, mem_done;
    logic [31:0] mem_rdata;
    logic        m_start, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_busy, m_done;
    logic [31:0] m_rdata;
    logic        proto_err;

    axi_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .resetn(resetn),
        .if_start(if_start), .if_addr(if_addr),
        .if_busy(if_busy), .if_done(if_done), .if_rdata(if_rdata),
        .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .m_start(m_start), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } req_t;

    req_t if_q[$];
    req_t mem_q[$];
    int   grant_log[$];

    int cyc = 0;
    int passes = 0;
    int checks = 0;
    int infl = NONE;
    int prev_infl = NONE;
    bit prev_mbusy = 1'b0;
    bit prev_ok = 1'b0;
    bit after_reset = 1'b0;
    int streak = 0;
    int viol_cyc = -1;

    int          fix_delay = 0;
    logic [31:0] fix_rdata = '0;
    bit          use_fix_rdata = 1'b0;
    bit          stray_req = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input string msg);
        checks++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Master model: busy from m_start until done after a delay, optional busy tail.
    initial begin
        int cnt;
        int tail;
        cnt = 0;
        tail = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_done = 1'b0;
            if (!resetn) begin
                cnt = 0;
                tail = 0;
                m_busy = 1'b0;
            end else if (stray_req) begin
                m_done = 1'b1;
                m_rdata = $urandom;
                stray_req = 1'b0;
            end else if (m_start) begin
                m_busy = 1'b1;
                cnt = (fix_delay > 0) ? fix_delay : int'($urandom_range(1, 4));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    m_done = 1'b1;
                    m_rdata = use_fix_rdata ? fix_rdata : $urandom;
                    tail = (fix_delay > 0) ? 0 : int'($urandom_range(0, 2));
                    m_busy = (tail > 0);
                end
            end else if (tail > 0) begin
                tail--;
                if (tail == 0) m_busy = 1'b0;
            end
        end
    end

    // Monitor and reference model.
    always @(negedge clk) begin
        req_t r;
        bit   elig_if, elig_mem, exp_start, pick_if, exp_if_busy, exp_mem_busy, exp_p;
        if (!resetn) begin
            if_q.delete();
            mem_q.delete();
            infl = NONE;
            prev_infl = NONE;
            prev_mbusy = 1'b0;
            prev_ok = 1'b0;
            streak = 0;
            viol_cyc = -1;
            after_reset = 1'b1;
        end else begin
            if (after_reset) begin
                chk("rst_m_start", m_start, 0);
                chk("rst_m_we", m_we, 0);
                chk("rst_m_addr", m_addr, 0);
                chk("rst_m_wdata", m_wdata, 0);
                chk("rst_m_wstrb", m_wstrb, 0);
                chk("rst_proto_err", proto_err, 0);
                after_reset = 1'b0;
            end

            exp_if_busy  = (if_q.size() > 0 && if_q[0].cyc < cyc) || (infl == OWN_IF);
            exp_mem_busy = (mem_q.size() > 0 && mem_q[0].cyc < cyc) || (infl == OWN_MEM);
            chk("if_busy", if_busy, exp_if_busy);
            chk("mem_busy", mem_busy, exp_mem_busy);

            // A request issued in cycle t is visible to arbitration in t+1 and
            // can reach the master in t+2 at the earliest.
            elig_if   = (if_q.size() > 0)  && (if_q[0].cyc + 2 <= cyc);
            elig_mem  = (mem_q.size() > 0) && (mem_q[0].cyc + 2 <= cyc);
            exp_start = prev_ok && (prev_infl == NONE) && !prev_mbusy && (elig_if || elig_mem);
            if (m_start || exp_start) chk("m_start", m_start, exp_start);
            if (m_start && exp_start) begin
                pick_if = elig_if && (!elig_mem || (SMAX > 0 && streak == SMAX));
                if (pick_if) begin
                    r = if_q.pop_front();
                    streak = 0;
                    infl = OWN_IF;
                    grant_log.push_back(OWN_IF);
                end else begin
                    r = mem_q.pop_front();
                    if (!elig_if) streak = 0;
                    else if (streak < SMAX) streak++;
                    infl = OWN_MEM;
                    grant_log.push_back(OWN_MEM);
                    chk("m_wdata", m_wdata, r.wdata);
                end
                chk("m_we", m_we, r.we);
                chk("m_addr", m_addr, r.addr);
                chk("m_wstrb", m_wstrb, r.wstrb);
            end

            if (m_done) begin
                if (infl == OWN_IF) begin
                    chk("if_done", if_done, 1);
                    chk("if_rdata", if_rdata, m_rdata);
                    chk("mem_done_idle", mem_done, 0);
                end else if (infl == OWN_MEM) begin
                    chk("mem_done", mem_done, 1);
                    chk("mem_rdata", mem_rdata, m_rdata);
                    chk("if_done_idle", if_done, 0);
                end else begin
                    chk("stray_if_done", if_done, 0);
                    chk("stray_mem_done", mem_done, 0);
                end
            end else if (if_done || mem_done) begin
                chk("spurious_done", {if_done, mem_done}, 0);
            end

            exp_p = (viol_cyc >= 0) && (cyc > viol_cyc);
            if (proto_err || exp_p) chk("proto_err", proto_err, exp_p);

            prev_infl = infl;
            if (m_done) infl = NONE;
            prev_mbusy = m_busy;
            prev_ok = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        if_start = 1'b0;
        mem_start = 1'b0;
    endtask

    task automatic issue_if(input logic [31:0] a);
        req_t r;
        if_start = 1'b1;
        if_addr = a;
        r.we = 1'b0; r.addr = a; r.wdata = '0; r.wstrb = '0; r.cyc = cyc;
        if_q.push_back(r);
    endtask

    task automatic issue_mem(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        mem_start = 1'b1;
        mem_we = we; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        r.we = we; r.addr = a; r.wdata = d; r.wstrb = s; r.cyc = cyc;
        mem_q.push_back(r);
    endtask

    function automatic bit can_if();
        return (if_q.size() == 0) && ((infl != OWN_IF) || m_done);
    endfunction

    function automatic bit can_mem();
        return (mem_q.size() == 0) && ((infl != OWN_MEM) || m_done);
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (!(if_q.size() == 0 && mem_q.size() == 0 && infl == NONE && !m_busy)) begin
            step();
            n++;
            if (n > budget) begin
                fail_now(tag, "timeout, arbiter never drained");
                return;
            end
        end
        step();
        step();
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        repeat (n) step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        int marker, n, re;
        resetn = 1'b0;
        if_start = 1'b0; if_addr = '0;
        mem_start = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (3) step();
        resetn = 1'b1;
        step();

        // Single IF read with fixed master latency.
        fix_delay = 3; fix_rdata = 32'h2402000A; use_fix_rdata = 1'b1;
        issue_if(32'h34);
        wait_idle(50, "t1_idle");

        // Simultaneous requests: MEM wins first.
        fix_delay = 0; use_fix_rdata = 1'b0;
        marker = grant_log.size();
        issue_if(32'h38);
        issue_mem(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF);
        wait_idle(100, "t2_idle");
        if (grant_log.size() >= marker + 2) begin
            chk("t2_first_grant", grant_log[marker], OWN_MEM);
            chk("t2_second_grant", grant_log[marker + 1], OWN_IF);
        end else fail_now("t2_grants", "fewer than 2 grants observed");

        // Starvation limit: MEM re-requests at each of its dones.
        marker = grant_log.size();
        issue_if(32'h3C);
        issue_mem(1'b0, 32'h2000, '0, 4'h0);
        n = 0; re = 0;
        while (re < 2 && n < 200) begin
            step();
            n++;
            if (infl == OWN_MEM && m_done && mem_q.size() == 0) begin
                issue_mem(1'b0, 32'h2004 + 32'(re * 4), '0, 4'h0);
                re++;
            end
        end
        if (re < 2) fail_now("t3_reissue", "MEM done not seen in time");
        wait_idle(200, "t3_idle");
        if (grant_log.size() >= marker + 4) begin
            chk("t3_grant0", grant_log[marker], OWN_MEM);
            chk("t3_grant1", grant_log[marker + 1], OWN_MEM);
            chk("t3_grant2", grant_log[marker + 2], OWN_IF);
            chk("t3_grant3", grant_log[marker + 3], OWN_MEM);
        end else fail_now("t3_grants", "fewer than 4 grants observed");

        // Back-to-back IF: restart in the done cycle.
        issue_if(32'h40);
        n = 0;
        while (!(infl == OWN_IF && m_done) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) fail_now("t4_done", "IF done not seen in time");
        else issue_if(32'h44);
        wait_idle(100, "t4_idle");

        // Protocol violation: second MEM start while busy is dropped.
        issue_mem(1'b1, 32'h3000, 32'h12345678, 4'h3);
        step();
        mem_start = 1'b1; mem_we = 1'b1; mem_addr = 32'h3004; mem_wdata = 32'h0BADF00D; mem_wstrb = 4'hF;
        viol_cyc = cyc;
        wait_idle(100, "t5_idle");

        // Reset while waiting on the master, then a stray completion.
        fix_delay = 6;
        issue_if(32'h50);
        n = 0;
        while (infl != OWN_IF && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) fail_now("t6_grant", "IF grant not seen in time");
        step();
        do_reset(2);
        stray_req = 1'b1;
        step();
        step();
        fix_delay = 0;
        issue_if(32'h54);
        wait_idle(100, "t6_idle");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step();
            if (can_if() && $urandom_range(0, 2) == 0) issue_if($urandom);
            if (can_mem() && $urandom_range(0, 2) == 0)
                issue_mem(1'($urandom), $urandom, $urandom, 4'($urandom));
        end
        wait_idle(200, "rand_idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
